// File: rtl/controlador_sincronizacion_vga_if.sv
// rtl/controlador_sincronizacion_vga_if.sv - scan-timing bundle between the VGA sync controller and pixel generators
interface controlador_sincronizacion_vga_if #(
  parameter int COORD_W = 10
);
  logic               pix_en;
  logic               hsync;
  logic               vsync;
  logic               visible;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, visible, x, y, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, visible, x, y, frame_start
  );
endinterface

// File: rtl/controlador_sincronizacion_vga.sv
// rtl/controlador_sincronizacion_vga.sv - VGA horizontal/vertical sync FSMs, visible flag, coordinates and frame-start pulse
module controlador_sincronizacion_vga #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COORD_W   = 10
) (
  input  logic clk_referencia,
  input  logic reset,
  controlador_sincronizacion_vga_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST        = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_FRONT_START = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] H_SYNC_START  = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] H_BACK_START  = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_LAST        = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_FRONT_START = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] V_SYNC_START  = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] V_BACK_START  = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_VISIBLE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } scan_state_e;

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  scan_state_e        h_state_q, h_state_d;
  scan_state_e        v_state_q, v_state_d;
  logic               h_wrap;
  logic               visible_d;

  logic               hsync_q;
  logic               vsync_q;
  logic               visible_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               frame_start_q;

  // Next position and states; outputs are registered from these so they match the counters held.
  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + COORD_W'(1);
    v_cnt_d   = v_cnt_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;

    if (h_cnt_d == '0)                h_state_d = ST_VISIBLE;
    else if (h_cnt_d == H_FRONT_START) h_state_d = ST_FRONT;
    else if (h_cnt_d == H_SYNC_START)  h_state_d = ST_SYNC;
    else if (h_cnt_d == H_BACK_START)  h_state_d = ST_BACK;

    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COORD_W'(1);
      if (v_cnt_d == '0)                v_state_d = ST_VISIBLE;
      else if (v_cnt_d == V_FRONT_START) v_state_d = ST_FRONT;
      else if (v_cnt_d == V_SYNC_START)  v_state_d = ST_SYNC;
      else if (v_cnt_d == V_BACK_START)  v_state_d = ST_BACK;
    end

    visible_d = (h_state_d == ST_VISIBLE) && (v_state_d == ST_VISIBLE);
  end

  always_ff @(posedge clk_referencia or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      h_state_q     <= ST_BACK;
      v_state_q     <= ST_BACK;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (vga.pix_en) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        h_state_q     <= h_state_d;
        v_state_q     <= v_state_d;
        hsync_q       <= (h_state_d != ST_SYNC);
        vsync_q       <= (v_state_d != ST_SYNC);
        visible_q     <= visible_d;
        x_q           <= visible_d ? h_cnt_d : '0;
        y_q           <= visible_d ? v_cnt_d : '0;
        frame_start_q <= (h_cnt_d == '0) && (v_cnt_d == '0);
      end
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.visible     = visible_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;

endmodule
